// File: rtl/fullconnect_pkg.sv
// Shared types and constants for the FullConnect memory-window slave.
package fullconnect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_ACK  = 2'd2,
        ST_WR_ACK  = 2'd3
    } fc_state_t;

    localparam int FC_BYTES_PER_WORD = 64;
    localparam int FC_WORD_SHIFT     = 6;

endpackage

// File: rtl/fullconnect_bram.sv
// Single-port scratchpad: byte-masked write, READ_LAT-stage registered read.
module fullconnect_bram #(
    parameter int DEPTH    = 512,
    parameter int DATA_W   = 512,
    parameter int BE_W     = 64,
    parameter int READ_LAT = 2,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_rd,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [BE_W-1:0]   i_be,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0]                r_mem [DEPTH];
    logic [READ_LAT-1:0][DATA_W-1:0]  r_pipe;

    // Byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    // Read pipeline: stage 0 captures on a read, later stages free-run so
    // the result settles and then holds until the next read.
    always_ff @(posedge clk) begin
        if (i_rd) r_pipe[0] <= r_mem[i_addr];
        for (int s = 1; s < READ_LAT; s++) r_pipe[s] <= r_pipe[s-1];
    end

    assign o_rdata = r_pipe[READ_LAT-1];

endmodule

// File: rtl/fullconnect_mem_slave.sv
// Avalon-MM waitrequest-only slave fronting one on-chip memory window.
// Holds the handshake FSM, address decode, sticky error and access counters.
module fullconnect_mem_slave
    import fullconnect_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          DEPTH_WORDS = 512,
    parameter int          DATA_W      = 512,
    parameter int          BE_W        = 64,
    parameter int          READ_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [BE_W-1:0]   avs_byteenable,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    input  logic              avs_lock,
    output logic              avs_waitrequest,
    output logic              err_o,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          CW        = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [63:0] WIN_BYTES = 64'(DEPTH_WORDS) << FC_WORD_SHIFT;

    fc_state_t         r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_rd_ok;
    logic              r_waitreq;
    logic [DATA_W-1:0] r_readdata;
    logic              r_err;
    logic [31:0]       r_rd_cnt;
    logic [31:0]       r_wr_cnt;

    logic [63:0]       w_off;
    logic              w_ok;
    logic [AW-1:0]     w_word;
    logic              w_ram_rd;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_q;
    logic              w_unused;

    // Decode the live address; reads use it in IDLE, writes in WR_ACK.
    always_comb begin
        w_off  = avs_address - BASE_ADDR;
        w_ok   = (avs_address >= BASE_ADDR) && (w_off < WIN_BYTES) &&
                 (avs_address[FC_WORD_SHIFT-1:0] == '0);
        w_word = w_off[AW+FC_WORD_SHIFT-1:FC_WORD_SHIFT];
    end

    // Lock has no effect with a single master; fold it away with spare offset bits.
    assign w_unused = ^{avs_lock, w_off};

    // A write in WR_ACK is suppressed when reset lands on the same edge.
    assign w_ram_rd = (r_state == ST_IDLE) && avs_read && !avs_write && w_ok;
    assign w_ram_we = (r_state == ST_WR_ACK) && w_ok && !rst;

    fullconnect_bram #(
        .DEPTH    (DEPTH_WORDS),
        .DATA_W   (DATA_W),
        .BE_W     (BE_W),
        .READ_LAT (READ_LAT),
        .AW       (AW)
    ) u_bram (
        .clk     (clk),
        .i_rd    (w_ram_rd),
        .i_we    (w_ram_we),
        .i_addr  (w_word),
        .i_be    (avs_byteenable),
        .i_wdata (avs_writedata),
        .o_rdata (w_ram_q)
    );

    // Handshake FSM with registered waitrequest/readdata, error and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rd_ok    <= 1'b0;
            r_waitreq  <= 1'b1;
            r_readdata <= '0;
            r_err      <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_waitreq <= 1'b1;
                    if (avs_write) begin
                        // Write wins a read/write collision but flags it.
                        r_state   <= ST_WR_ACK;
                        r_waitreq <= 1'b0;
                        if (avs_read) r_err <= 1'b1;
                    end else if (avs_read) begin
                        r_rd_ok <= w_ok;
                        r_cnt   <= CW'(READ_LAT - 1);
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (!avs_read) begin
                        // Master gave up mid-read: protocol violation.
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_state    <= ST_RD_ACK;
                        r_waitreq  <= 1'b0;
                        r_readdata <= r_rd_ok ? w_ram_q : '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_RD_ACK: begin
                    r_waitreq <= 1'b1;
                    r_rd_cnt  <= r_rd_cnt + 32'd1;
                    if (!r_rd_ok) r_err <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                ST_WR_ACK: begin
                    r_waitreq <= 1'b1;
                    r_wr_cnt  <= r_wr_cnt + 32'd1;
                    if (!w_ok) r_err <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_waitreq <= 1'b1;
                end
            endcase
        end
    end

    assign avs_readdata    = r_readdata;
    assign avs_waitrequest = r_waitreq;
    assign err_o           = r_err;
    assign rd_cnt_o        = r_rd_cnt;
    assign wr_cnt_o        = r_wr_cnt;

endmodule

// File: tb/tb_fullconnect_mem_slave.sv
// Scoreboard bench for fullconnect_mem_slave: expected read data is queued
// when a request is driven and popped when the slave accepts it.
module tb_fullconnect_mem_slave;

    localparam logic [63:0] BASE  = 64'h0000_0000_0001_0000;
    localparam int          DEPTH = 512;
    localparam int          RL    = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  avs_address = '0;
    logic         avs_read = 1'b0;
    logic         avs_write = 1'b0;
    logic [63:0]  avs_byteenable = '0;
    logic [511:0] avs_writedata = '0;
    logic [511:0] avs_readdata;
    logic         avs_lock = 1'b0;
    logic         avs_waitrequest;
    logic         err_o;
    logic [31:0]  rd_cnt_o;
    logic [31:0]  wr_cnt_o;

    always #5 clk = ~clk;

    fullconnect_mem_slave #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .DATA_W(512), .BE_W(64), .READ_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_byteenable(avs_byteenable),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_lock(avs_lock), .avs_waitrequest(avs_waitrequest), .err_o(err_o),
        .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o)
    );

    int           n_chk = 0;
    int           n_fail = 0;
    int           exp_rd = 0;
    int           exp_wr = 0;
    logic [511:0] exp_q [$];
    logic [511:0] mdl [DEPTH];

    function automatic logic addr_ok(input logic [63:0] a);
        logic [63:0] lim;
        lim = BASE + 64'(DEPTH * 64);
        return (a >= BASE) && (a < lim) && (a[5:0] == 6'd0);
    endfunction

    function automatic logic [63:0] waddr(input int w);
        return BASE + 64'(w * 64);
    endfunction

    task automatic mdl_write(input logic [63:0] a, input logic [511:0] d, input logic [63:0] be);
        int w;
        if (addr_ok(a)) begin
            w = int'((a - BASE) >> 6);
            for (int b = 0; b < 64; b++) if (be[b]) mdl[w][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic idle_bus();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_bus();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
    endtask

    // Cycles from request (cycle 0) to the accept cycle; -1 on timeout.
    task automatic wait_accept(output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [511:0] d,
                             input logic [63:0] be, output int lat);
        @(posedge clk); #1;
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        wait_accept(lat);
        mdl_write(a, d, be);
        exp_wr++;
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic bus_read(input logic [63:0] a, output logic [511:0] data, output int lat);
        @(posedge clk); #1;
        avs_address = a; avs_read = 1'b1;
        wait_accept(lat);
        data = avs_readdata;
        exp_rd++;
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_chk++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_waitreq got %b want 1", avs_waitrequest); end
        n_chk++; if (avs_readdata !== '0) begin n_fail++; $display("FAIL rst_readdata got %h want 0", avs_readdata); end
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err_o); end
        n_chk++; if (rd_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rst_rd_cnt got %0d want 0", rd_cnt_o); end
        n_chk++; if (wr_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rst_wr_cnt got %0d want 0", wr_cnt_o); end
    endtask

    task automatic test_write_read();
        int lat; logic [511:0] got;
        bus_write(BASE, {64{8'hA5}}, '1, lat);
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL wr_latency got %0d want 1", lat); end
        exp_q.push_back({64{8'hA5}});
        bus_read(BASE, got, lat);
        n_chk++; if (lat !== RL + 1) begin n_fail++; $display("FAIL rd_latency got %0d want %0d", lat, RL + 1); end
        n_chk++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL rd_word0 got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_byteenable();
        int lat; logic [511:0] got;
        bus_write(waddr(5), {64{8'h11}}, '1, lat);
        bus_write(waddr(5), {64{8'hFF}}, 64'h0F, lat);
        n_chk++; if (avs_readdata !== {64{8'hA5}}) begin n_fail++; $display("FAIL rdata_hold got %h want a5..", avs_readdata); end
        exp_q.push_back({{60{8'h11}}, {4{8'hFF}}});
        bus_read(waddr(5), got, lat);
        n_chk++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL be_merge got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
        n_chk++; if (wr_cnt_o !== 32'(exp_wr)) begin n_fail++; $display("FAIL be_wr_cnt got %0d want %0d", wr_cnt_o, exp_wr); end
    endtask

    task automatic test_decode_err();
        int lat; logic [511:0] got;
        logic [63:0] bad [3];
        bad[0] = BASE + 64'(64 * DEPTH);
        bad[1] = BASE + 64'h20;
        bad[2] = BASE - 64'h40;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('0);
            bus_read(bad[i], got, lat);
            n_chk++; if (lat !== RL + 1) begin n_fail++; $display("FAIL bad_rd_lat[%0d] got %0d want %0d", i, lat, RL + 1); end
            n_chk++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL bad_rd_data[%0d] got %h want 0", i, got); end
            void'(exp_q.pop_front());
        end
        // Misaligned write aliasing word 5 must be dropped.
        bus_write(waddr(5) + 64'h4, '0, '1, lat);
        exp_q.push_back(mdl[5]);
        bus_read(waddr(5), got, lat);
        n_chk++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL bad_wr_dropped got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
        n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL decode_err got %b want 1", err_o); end
        n_chk++; if (rd_cnt_o !== 32'(exp_rd)) begin n_fail++; $display("FAIL decode_rd_cnt got %0d want %0d", rd_cnt_o, exp_rd); end
        n_chk++; if (wr_cnt_o !== 32'(exp_wr)) begin n_fail++; $display("FAIL decode_wr_cnt got %0d want %0d", wr_cnt_o, exp_wr); end
    endtask

    task automatic test_collision();
        int lat; logic [511:0] got;
        do_reset();
        @(posedge clk); #1;
        avs_address = waddr(3); avs_writedata = {64{8'h77}}; avs_byteenable = '1;
        avs_read = 1'b1; avs_write = 1'b1;
        wait_accept(lat);
        mdl_write(waddr(3), {64{8'h77}}, '1);
        exp_wr++;
        @(posedge clk); #1;
        idle_bus();
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL coll_latency got %0d want 1", lat); end
        n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL coll_err got %b want 1", err_o); end
        exp_q.push_back({64{8'h77}});
        bus_read(waddr(3), got, lat);
        n_chk++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL coll_data got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
        n_chk++; if (rd_cnt_o !== 32'(exp_rd) || wr_cnt_o !== 32'(exp_wr)) begin
            n_fail++; $display("FAIL coll_cnt got rd=%0d wr=%0d want rd=%0d wr=%0d", rd_cnt_o, wr_cnt_o, exp_rd, exp_wr);
        end
    endtask

    task automatic test_abort_and_reset();
        int lat; logic [511:0] got;
        do_reset();
        @(posedge clk); #1;
        avs_address = BASE; avs_read = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL abort_waitreq got %b want 1", avs_waitrequest); end
        n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL abort_err got %b want 1", err_o); end
        n_chk++; if (rd_cnt_o !== 32'd0) begin n_fail++; $display("FAIL abort_rd_cnt got %0d want 0", rd_cnt_o); end
        // Reset lands on the WR_ACK edge: the write must not happen.
        bus_write(waddr(9), {64{8'h33}}, '1, lat);
        @(posedge clk); #1;
        avs_address = waddr(9); avs_writedata = {64{8'hCC}}; avs_byteenable = '1; avs_write = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_bus();
        exp_rd = 0; exp_wr = 0;
        @(negedge clk);
        n_chk++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_wrack_waitreq got %b want 1", avs_waitrequest); end
        exp_q.push_back({64{8'h33}});
        bus_read(waddr(9), got, lat);
        n_chk++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL rst_wrack_data got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_back_to_back();
        int lat, cyc, last, acc;
        logic [511:0] pat;
        do_reset();
        for (int w = 0; w < 8; w++) begin
            pat = {64{8'(w * 16 + 3)}};
            bus_write(waddr(w), pat, '1, lat);
        end
        @(posedge clk); #1;
        avs_address = waddr(0); avs_read = 1'b1;
        exp_q.push_back(mdl[0]);
        last = -1; acc = 0;
        for (cyc = 0; cyc < 200 && acc < 8; cyc++) begin
            @(negedge clk);
            avs_lock = ~avs_lock;
            if (!avs_waitrequest) begin
                n_chk++; if (avs_readdata !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", acc, avs_readdata, exp_q[0]); end
                void'(exp_q.pop_front());
                n_chk++;
                if ((acc == 0 && cyc != RL + 1) || (acc > 0 && cyc - last != RL + 2)) begin
                    n_fail++; $display("FAIL b2b_spacing[%0d] got cycle %0d prev %0d", acc, cyc, last);
                end
                last = cyc;
                acc++;
                exp_rd++;
                if (acc < 8) begin
                    avs_address = waddr(acc);
                    exp_q.push_back(mdl[acc]);
                end
            end
        end
        @(posedge clk); #1;
        idle_bus();
        avs_lock = 1'b0;
        @(negedge clk);
        n_chk++; if (acc !== 8) begin n_fail++; $display("FAIL b2b_accepts got %0d want 8", acc); end
        n_chk++; if (rd_cnt_o !== 32'(exp_rd)) begin n_fail++; $display("FAIL b2b_rd_cnt got %0d want %0d", rd_cnt_o, exp_rd); end
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b want 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_decode_err();
        test_collision();
        test_abort_and_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
